fsm_en_sched: RTL and testbench
===============================

Name: fsm_en_sched

Overview:
- Round-robin scheduler that shares one `fsm` instance (inputs `en`, output `dout[3:0]`) among several requesters.
- Each grant drives `en` high for a fixed burst of cycles, then enforces an idle gap.
- At the end of the burst it captures the fsm's `dout` and returns it to the granted requester.
- Sits between the requester logic and the `fsm` datapath; owns the fsm's `en` input exclusively.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- BURST, 3, cycles `en` is held high per grant (>=1).
- GAP, 3, cycles `en` is held low after each burst before the next grant (>=0).
- IDW, 2, width of `gnt_id` (must satisfy 2**IDW >= N_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request, level-sensitive.
- fsm_dout  in  4  `dout` of the shared fsm.
- fsm_en  out  1  drives `en` of the shared fsm.
- gnt  out  N_REQ  one-hot grant, high for the whole burst.
- gnt_id  out  IDW  binary index of the current/last grantee.
- busy  out  1  high in BURST or GAP.
- result  out  4  fsm_dout captured at end of burst.
- result_vld  out  1  one-cycle pulse, result valid.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-burst):
  - fsm_en, gnt, gnt_id, busy, result and result_vld clear to 0 immediately.
  - The state goes to IDLE.
  - The round-robin pointer clears so requester 0 has highest priority.
- All outputs are registered.
- State machine: IDLE, BURST, GAP.
- IDLE:
  - On the edge where req!=0, pick the winner by round-robin.
  - Search order starts at pointer, incrementing and wrapping at N_REQ-1 -> 0.
  - At that same edge: gnt[w]=1, gnt_id=w, fsm_en=1, busy=1, cnt=BURST-1, pointer=w+1 (wraps); go to BURST.
  - Result: fsm_en is high starting the cycle after req is first sampled.
- BURST:
  - fsm_en=1 for exactly BURST cycles; cnt decrements each edge.
  - At the edge with cnt==0:
    - fsm_en=0, gnt=0, result<=fsm_dout sampled at that edge, result_vld=1 for the next cycle.
    - If GAP>0: cnt=GAP-1, go to GAP.
    - If GAP==0: go to IDLE, and in the same edge perform IDLE arbitration so back-to-back bursts are possible. In that case result_vld and the new gnt coexist.
- GAP:
  - fsm_en=0, busy=1, req ignored.
  - At the edge with cnt==0, go to IDLE with busy=0; arbitration happens on the following edge.
- Request handling:
  - req deasserting during BURST or GAP does not shorten the burst.
  - req asserting during BURST or GAP is held off until IDLE.
  - req is never latched; a requester must keep req high until it sees its gnt.
- Invariants:
  - gnt is zero or one-hot.
  - gnt_id retains its last value after the burst.
  - result holds until the next capture.
- Counter width: ceil(log2(max(BURST,GAP,1)))+1 bits; no wrap is possible within a state.
- Simultaneous requests: the grant goes to the first requester at or after the pointer; all others wait.
- No starvation: with all req high, grants rotate 0,1,2,3,0…

Test Plan:
- Reset mid-burst: assert rst_n=0 in cycle 2 of a burst -> fsm_en, gnt and busy are 0 within the same cycle (asynchronous); after release, req=4'b1111 grants requester 0 first.
- Single request: req=4'b0100 held from cycle 10 -> gnt=4'b0100, gnt_id=2, fsm_en high cycles 11-13; busy through cycle 16; result_vld pulse at cycle 14 with result = fsm_dout sampled at that edge.
- Round-robin: req=4'b1111 continuously -> gnt sequence 0001, 0010, 0100, 1000, 0001; each burst 3 cycles, separated by 3 gap cycles plus 1 arbitration cycle.
- Late and withdrawn requests: req[1] pulses high only during requester 3's burst -> no grant to 1. req[0] dropped mid-burst -> burst still runs a full 3 cycles.
- GAP=0, BURST=1, req=4'b0011 held -> fsm_en stays high continuously; gnt alternates 0001/0010 every cycle; result_vld high every cycle after the first.
- Pointer wrap: after a grant to 3, req=4'b1001 -> grant goes to 0, then 3.

Source files
------------

// File: rtl/fsm_en_sched_if.sv
// -----------------------------------------------------------------------------
// fsm_en_sched_if
// Bundle of signals between the round-robin enable scheduler, its requesters
// and the shared fsm datapath.
//
//   req        requester -> scheduler  per-requester level request
//   fsm_dout   fsm       -> scheduler  dout of the shared fsm
//   fsm_en     scheduler -> fsm        en of the shared fsm
//   gnt        scheduler -> requesters one-hot grant, high for the burst
//   gnt_id     scheduler -> requesters binary index of current/last grantee
//   busy       scheduler -> requesters high while in BURST or GAP
//   result     scheduler -> requesters fsm_dout captured at end of burst
//   result_vld scheduler -> requesters one-cycle pulse, result valid
//
// Modports: "slave" is the scheduler's view, "master" is the environment's
// (requesters plus fsm) view.
// -----------------------------------------------------------------------------
interface fsm_en_sched_if #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
);
    logic [N_REQ-1:0] req;
    logic [3:0]       fsm_dout;
    logic             fsm_en;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_id;
    logic             busy;
    logic [3:0]       result;
    logic             result_vld;

    modport master (
        output req,
        output fsm_dout,
        input  fsm_en,
        input  gnt,
        input  gnt_id,
        input  busy,
        input  result,
        input  result_vld
    );

    modport slave (
        input  req,
        input  fsm_dout,
        output fsm_en,
        output gnt,
        output gnt_id,
        output busy,
        output result,
        output result_vld
    );
endinterface

// File: rtl/fsm_en_sched.sv
// -----------------------------------------------------------------------------
// fsm_en_sched
// Round-robin scheduler sharing one fsm instance among N_REQ requesters.
// A grant holds the fsm's en high for BURST cycles, then en is held low for
// GAP cycles before the next arbitration. At the edge that ends the burst the
// fsm's dout is captured and presented on result with a one-cycle result_vld.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of fsm_en_sched_if (req, fsm_dout in;
//          fsm_en, gnt, gnt_id, busy, result, result_vld out)
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module fsm_en_sched #(
    parameter int N_REQ = 4,
    parameter int BURST = 3,
    parameter int GAP   = 3,
    parameter int IDW   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    fsm_en_sched_if.slave       bus
);

    // Counter only ever holds BURST-1 or GAP-1 downwards, so this never wraps.
    localparam int CNT_MAX = (BURST > GAP) ? BURST : ((GAP > 1) ? GAP : 1);
    localparam int CW      = $clog2(CNT_MAX) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Round-robin pick: returns {found, index} of the first asserted request
    // at or after ptr, wrapping from N_REQ-1 back to 0.
    // -------------------------------------------------------------------------
    function automatic logic [IDW:0] rr_pick(
        input logic [N_REQ-1:0] req_v,
        input logic [IDW-1:0]   ptr_v
    );
        logic           found;
        logic [IDW-1:0] win;
        int             idx;
        found = 1'b0;
        win   = {IDW{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr_v) + i) % N_REQ;
            if (!found && req_v[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end else begin
                found = found;
            end
        end
        return {found, win};
    endfunction

    // Pointer successor of a winner, wrapping at N_REQ-1 (N_REQ need not be a
    // power of two, so plain IDW-bit overflow is not enough).
    function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] w);
        logic [IDW-1:0] nxt;
        if (int'(w) == (N_REQ - 1)) begin
            nxt = {IDW{1'b0}};
        end else begin
            nxt = w + IDW'(1);
        end
        return nxt;
    endfunction

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [IDW-1:0]   r_ptr;
    logic             r_fsm_en;
    logic [N_REQ-1:0] r_gnt;
    logic [IDW-1:0]   r_gnt_id;
    logic             r_busy;
    logic [3:0]       r_result;
    logic             r_result_vld;

    // Next-state values
    state_t           w_state_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [IDW-1:0]   w_ptr_nxt;
    logic             w_fsm_en_nxt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [IDW-1:0]   w_gnt_id_nxt;
    logic             w_busy_nxt;
    logic [3:0]       w_result_nxt;
    logic             w_result_vld_nxt;

    logic             w_arb_en;
    logic [IDW:0]     w_pick;
    logic             w_pick_found;
    logic [IDW-1:0]   w_pick_id;
    logic [N_REQ-1:0] w_pick_onehot;

    assign w_pick        = rr_pick(bus.req, r_ptr);
    assign w_pick_found  = w_pick[IDW];
    assign w_pick_id     = w_pick[IDW-1:0];
    assign w_pick_onehot = N_REQ'(1) << w_pick_id;

    // Next-state and next-output logic for the IDLE/BURST/GAP machine.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_ptr_nxt        = r_ptr;
        w_fsm_en_nxt     = r_fsm_en;
        w_gnt_nxt        = r_gnt;
        w_gnt_id_nxt     = r_gnt_id;
        w_busy_nxt       = r_busy;
        w_result_nxt     = r_result;
        w_result_vld_nxt = 1'b0;
        w_arb_en         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_arb_en = 1'b1;
            end

            ST_BURST: begin
                if (r_cnt == {CW{1'b0}}) begin
                    // Last burst cycle: drop en, capture dout, pulse valid.
                    w_fsm_en_nxt     = 1'b0;
                    w_gnt_nxt        = {N_REQ{1'b0}};
                    w_result_nxt     = bus.fsm_dout;
                    w_result_vld_nxt = 1'b1;
                    if (GAP != 0) begin
                        w_cnt_nxt   = CW'(GAP - 1);
                        w_state_nxt = ST_GAP;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        // No gap: arbitrate on this same edge so bursts can
                        // run back to back.
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_arb_en    = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end

            ST_GAP: begin
                if (r_cnt == {CW{1'b0}}) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_fsm_en_nxt = 1'b0;
                w_gnt_nxt    = {N_REQ{1'b0}};
                w_busy_nxt   = 1'b0;
            end
        endcase

        // Arbitration overrides the defaults above when a request wins.
        if (w_arb_en && w_pick_found) begin
            w_state_nxt  = ST_BURST;
            w_gnt_nxt    = w_pick_onehot;
            w_gnt_id_nxt = w_pick_id;
            w_fsm_en_nxt = 1'b1;
            w_busy_nxt   = 1'b1;
            w_cnt_nxt    = CW'(BURST - 1);
            w_ptr_nxt    = ptr_after(w_pick_id);
        end else begin
            w_ptr_nxt = w_ptr_nxt;
        end
    end

    // State, counter, pointer and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= {CW{1'b0}};
            r_ptr        <= {IDW{1'b0}};
            r_fsm_en     <= 1'b0;
            r_gnt        <= {N_REQ{1'b0}};
            r_gnt_id     <= {IDW{1'b0}};
            r_busy       <= 1'b0;
            r_result     <= 4'd0;
            r_result_vld <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ptr        <= w_ptr_nxt;
            r_fsm_en     <= w_fsm_en_nxt;
            r_gnt        <= w_gnt_nxt;
            r_gnt_id     <= w_gnt_id_nxt;
            r_busy       <= w_busy_nxt;
            r_result     <= w_result_nxt;
            r_result_vld <= w_result_vld_nxt;
        end
    end

    assign bus.fsm_en     = r_fsm_en;
    assign bus.gnt        = r_gnt;
    assign bus.gnt_id     = r_gnt_id;
    assign bus.busy       = r_busy;
    assign bus.result     = r_result;
    assign bus.result_vld = r_result_vld;

endmodule

// File: tb/tb_fsm_en_sched.sv
// -----------------------------------------------------------------------------
// tb_fsm_en_sched
// Two scheduler instances: A with BURST=3/GAP=3, B with BURST=1/GAP=0.
// A transaction-level model predicts, per grant, which requester wins and the
// cycles during which its grant is visible, and when a result appears and
// with what value. Predictions go into queues; a monitor on the falling edge
// pops and compares against what the DUTs present.
// -----------------------------------------------------------------------------
module tb_fsm_en_sched;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic [3:0] dout_s = 4'd0;

    fsm_en_sched_if #(.N_REQ(4), .IDW(2)) if_a ();
    fsm_en_sched_if #(.N_REQ(4), .IDW(2)) if_b ();

    fsm_en_sched #(.N_REQ(4), .BURST(3), .GAP(3), .IDW(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    fsm_en_sched #(.N_REQ(4), .BURST(1), .GAP(0), .IDW(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    assign if_a.fsm_dout = dout_s;
    assign if_b.fsm_dout = dout_s;

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int burst_len [2] = '{3, 1};
    int gap_len   [2] = '{3, 0};

    // Model state, per DUT
    int ptr        [2];
    int free_at    [2];
    int busy_until [2];
    int last_id    [2];
    int last_res   [2];
    int exp_g      [2][$];   // cycle*16 + granted index
    int exp_r      [2][$];   // cycle*16 + result value
    int pend_r     [2][$];   // cycle at which a result will be captured

    task automatic check(input string name, input int d, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, d, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ptr[d]        = 0;
            free_at[d]    = 0;
            busy_until[d] = -1;
            last_id[d]    = 0;
            last_res[d]   = 0;
            exp_g[d].delete();
            exp_r[d].delete();
            pend_r[d].delete();
        end
    endtask

    // One rising edge of the reference: capture due results, then arbitrate
    // if the scheduler is free and someone is asking.
    task automatic model_step(input int d, input logic [3:0] req, input logic [3:0] dout);
        int w;
        if (pend_r[d].size() > 0 && pend_r[d][0] == cyc) begin
            void'(pend_r[d].pop_front());
            exp_r[d].push_back(cyc * 16 + int'(dout));
            last_res[d] = int'(dout);
        end
        if (cyc >= free_at[d] && req != 4'd0) begin
            w = -1;
            for (int i = 0; i < 4; i++) begin
                if (w < 0 && req[(ptr[d] + i) % 4]) w = (ptr[d] + i) % 4;
            end
            for (int j = 0; j < burst_len[d]; j++) exp_g[d].push_back((cyc + j) * 16 + w);
            pend_r[d].push_back(cyc + burst_len[d]);
            last_id[d] = w;
            ptr[d]     = (w + 1) % 4;
            if (gap_len[d] > 0) begin
                busy_until[d] = cyc + burst_len[d] + gap_len[d] - 1;
                free_at[d]    = cyc + burst_len[d] + gap_len[d] + 1;
            end else begin
                busy_until[d] = cyc + burst_len[d] - 1;
                free_at[d]    = cyc + burst_len[d];
            end
        end
    endtask

    task automatic monitor(input int d, input logic [3:0] gnt, input logic [1:0] gid,
                           input logic en, input logic busy, input logic [3:0] res,
                           input logic vld);
        int e;
        while (exp_g[d].size() > 0 && exp_g[d][0] / 16 < cyc) begin
            e = exp_g[d].pop_front();
            check("grant_missed", d, 0, 1);
        end
        if (exp_g[d].size() > 0 && exp_g[d][0] / 16 == cyc) begin
            e = exp_g[d].pop_front();
            check("gnt", d, int'(gnt), 1 << (e % 16));
            check("fsm_en_on", d, int'(en), 1);
        end else begin
            check("gnt_idle", d, int'(gnt), 0);
            check("fsm_en_off", d, int'(en), 0);
        end
        check("gnt_id", d, int'(gid), last_id[d]);
        check("busy", d, int'(busy), (cyc <= busy_until[d]) ? 1 : 0);
        while (exp_r[d].size() > 0 && exp_r[d][0] / 16 < cyc) begin
            e = exp_r[d].pop_front();
            check("result_missed", d, 0, 1);
        end
        if (exp_r[d].size() > 0 && exp_r[d][0] / 16 == cyc) begin
            e = exp_r[d].pop_front();
            check("result_vld_on", d, int'(vld), 1);
            check("result_val", d, int'(res), e % 16);
        end else begin
            check("result_vld_off", d, int'(vld), 0);
            check("result_hold", d, int'(res), last_res[d]);
        end
    endtask

    // Reference model advances on every rising edge.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (rst_n) begin
                model_step(0, if_a.req, dout_s);
                model_step(1, if_b.req, dout_s);
            end
        end
    end

    // Monitor compares on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                monitor(0, if_a.gnt, if_a.gnt_id, if_a.fsm_en, if_a.busy, if_a.result, if_a.result_vld);
                monitor(1, if_b.gnt, if_b.gnt_id, if_b.fsm_en, if_b.busy, if_b.result, if_b.result_vld);
            end
        end
    end

    // Stand-in for the shared fsm: a fresh dout every cycle.
    initial begin
        forever begin
            @(negedge clk);
            dout_s = 4'($urandom_range(0, 15));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gnt_a(input int idx);
        int k;
        k = 0;
        while (!if_a.gnt[idx] && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("wait_gnt", 0, int'(if_a.gnt[idx]), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fsm_en"}, 0, int'(if_a.fsm_en), 0);
        check({tag, "_gnt"}, 0, int'(if_a.gnt), 0);
        check({tag, "_busy"}, 0, int'(if_a.busy), 0);
        check({tag, "_gnt_id"}, 0, int'(if_a.gnt_id), 0);
        check({tag, "_result"}, 0, int'(if_a.result), 0);
        check({tag, "_result_vld"}, 0, int'(if_a.result_vld), 0);
        check({tag, "_fsm_en"}, 1, int'(if_b.fsm_en), 0);
        check({tag, "_gnt"}, 1, int'(if_b.gnt), 0);
    endtask

    // Stimulus
    initial begin
        int k;
        if_a.req = 4'd0;
        if_b.req = 4'd0;
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("reset");
        cycles(2);
        rst_n = 1'b1;
        cycles(2);

        // Single request from requester 2
        if_a.req = 4'b0100;
        wait_gnt_a(2);
        check("single_gnt_id", 0, int'(if_a.gnt_id), 2);
        @(negedge clk);
        if_a.req = 4'b0000;
        cycles(10);

        // Everyone requesting: grants must rotate
        if_a.req = 4'b1111;
        cycles(36);
        if_a.req = 4'b0000;
        cycles(8);

        // Late request from 1 during requester 3's burst is not served
        if_a.req = 4'b1000;
        wait_gnt_a(3);
        if_a.req = 4'b1010;
        k = 0;
        while (if_a.gnt != 4'd0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("burst_end", 0, int'(if_a.gnt), 0);
        if_a.req = 4'b0000;
        cycles(8);

        // Pointer wrap: after a grant to 3, 1001 goes to 0 then 3
        if_a.req = 4'b1001;
        wait_gnt_a(0);
        wait_gnt_a(3);
        if_a.req = 4'b0000;
        cycles(8);

        // Request withdrawn mid-burst still gets the full burst
        if_a.req = 4'b0001;
        wait_gnt_a(0);
        if_a.req = 4'b0000;
        cycles(10);

        // Back-to-back bursts on the GAP=0, BURST=1 instance
        if_b.req = 4'b0011;
        cycles(14);
        if_b.req = 4'b0000;
        cycles(4);

        // Asynchronous reset in the second cycle of a burst
        if_a.req = 4'b1111;
        k = 0;
        while (!if_a.fsm_en && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check("pre_reset_en", 0, int'(if_a.fsm_en), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (if_a.gnt == 4'd0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("post_reset_first_gnt", 0, int'(if_a.gnt), 1);
        cycles(12);
        if_a.req = 4'b0000;
        cycles(8);

        // Random traffic on both instances
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) if_a.req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) if_b.req = 4'($urandom_range(0, 15));
        end
        if_a.req = 4'b0000;
        if_b.req = 4'b0000;
        cycles(12);

        check("drain_gnt", 0, exp_g[0].size() + exp_r[0].size(), 0);
        check("drain_gnt", 1, exp_g[1].size() + exp_r[1].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
